// File: rtl/vga_pkg.sv
// Shared VGA constants and the RRRGGGBB pixel type used by the frame-buffer read side.
package vga_pkg;

   localparam int H_VIS_DEF  = 640;
   localparam int H_FP_DEF   = 16;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF   = 48;
   localparam int V_VIS_DEF  = 480;
   localparam int V_FP_DEF   = 10;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF   = 33;

   localparam int FB_W  = 640;
   localparam int FB_H  = 480;
   localparam int FB_AW = 19;

   // Wide enough for 800 columns and 525 lines.
   localparam int CNT_W = 10;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel-enable divider plus horizontal/vertical raster counters with raw sync decode.
module vga_timing
   import vga_pkg::*;
#(
   parameter int H_VIS  = H_VIS_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_VIS  = V_VIS_DEF,
   parameter int V_FP   = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF
)(
   input  logic             clk,
   input  logic             reset,
   output logic             pix_en,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             visible,
   output logic             hs_raw,
   output logic             vs_raw
);

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
   localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);
   localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VIS + H_FP);
   localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VIS + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VIS + V_FP);
   localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VIS + V_FP + V_SYNC - 1);

   logic [1:0]       div_q, div_d;
   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;

   assign pix_en  = (div_q == 2'd3);
   assign h_cnt   = h_q;
   assign v_cnt   = v_q;
   assign visible = (h_q < H_VIS_C) && (v_q < V_VIS_C);
   assign hs_raw  = !((h_q >= HS_BEG) && (h_q <= HS_END));
   assign vs_raw  = !((v_q >= VS_BEG) && (v_q <= VS_END));

   always_comb begin
      div_d = div_q + 2'd1;
      h_d   = h_q;
      v_d   = v_q;
      if (pix_en) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
         end else begin
            h_d = h_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

endmodule

// File: rtl/vga_frame_reader.sv
// Scans the fractal frame buffer in raster order and drives VGA colour and sync.
module vga_frame_reader
   import vga_pkg::*;
#(
   parameter int RD_LAT = 1,
   parameter int H_VIS  = H_VIS_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_VIS  = V_VIS_DEF,
   parameter int V_FP   = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF
)(
   input  logic             Clk_100M,
   input  logic             reset,
   input  logic             display,
   input  logic [7:0]       rd_data,
   output logic [FB_AW-1:0] addr_r,
   output logic             rd_en,
   output logic             Hsync,
   output logic             Vsync,
   output logic [2:0]       vgaRed,
   output logic [2:0]       vgaGreen,
   output logic [1:0]       vgaBlue,
   output logic             frame_start
);

   logic             pix_en, visible, hs_raw, vs_raw;
   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic [FB_AW-1:0] pix_addr;
   logic             rd_cap;

   logic [FB_AW-1:0] addr_q, addr_d;
   logic             rd_en_q, rd_en_d;
   logic             rd_d1_q, rd_d1_d;
   logic [7:0]       pix_q, pix_d;
   logic             vis_q, vis_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             first_q, first_d;
   rgb332_t          col_q, col_d;
   logic             hsync_q, hsync_d;
   logic             vsync_q, vsync_d;
   logic             fs_q, fs_d;

   vga_timing #(
      .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .clk     (Clk_100M),
      .reset   (reset),
      .pix_en  (pix_en),
      .h_cnt   (h_cnt),
      .v_cnt   (v_cnt),
      .visible (visible),
      .hs_raw  (hs_raw),
      .vs_raw  (vs_raw)
   );

   assign pix_addr = FB_AW'(v_cnt) * FB_AW'(FB_W) + FB_AW'(h_cnt);

   // Read data lands RD_LAT cycles after the strobe; both cases finish before the next pix_en.
   assign rd_cap = (RD_LAT == 1) ? rd_en_q : rd_d1_q;

   always_comb begin
      addr_d  = addr_q;
      rd_en_d = 1'b0;
      rd_d1_d = rd_en_q;
      pix_d   = pix_q;
      vis_d   = vis_q;
      hs_d    = hs_q;
      vs_d    = vs_q;
      first_d = first_q;
      col_d   = col_q;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      fs_d    = 1'b0;
      if (rd_cap) begin
         pix_d = rd_data;
      end
      if (pix_en) begin
         if (visible) begin
            addr_d  = pix_addr;
            rd_en_d = 1'b1;
         end
         vis_d   = visible;
         hs_d    = hs_raw;
         vs_d    = vs_raw;
         first_d = (h_cnt == '0) && (v_cnt == '0);
         // Outputs present the pixel fetched one period ago, so sync rides with its colour.
         col_d   = (vis_q && display) ? rgb332_t'(pix_q) : '0;
         hsync_d = hs_q;
         vsync_d = vs_q;
         fs_d    = first_q;
      end
   end

   always_ff @(posedge Clk_100M) begin
      if (reset) begin
         addr_q  <= '0;
         rd_en_q <= 1'b0;
         rd_d1_q <= 1'b0;
         pix_q   <= '0;
         vis_q   <= 1'b0;
         hs_q    <= 1'b1;
         vs_q    <= 1'b1;
         first_q <= 1'b0;
         col_q   <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         fs_q    <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         rd_en_q <= rd_en_d;
         rd_d1_q <= rd_d1_d;
         pix_q   <= pix_d;
         vis_q   <= vis_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         first_q <= first_d;
         col_q   <= col_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         fs_q    <= fs_d;
      end
   end

   assign addr_r      = addr_q;
   assign rd_en       = rd_en_q;
   assign Hsync       = hsync_q;
   assign Vsync       = vsync_q;
   assign vgaRed      = col_q.r;
   assign vgaGreen    = col_q.g;
   assign vgaBlue     = col_q.b;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: two instances (RD_LAT 1 and 2) on a shrunken raster, raster model plus expected-pixel queue.
module tb_vga_frame_reader;

   localparam int HV = 64, HFP = 4, HSY = 8, HBP = 4;
   localparam int VV = 20, VFP = 2, VSY = 2, VBP = 3;
   localparam int HT = HV + HFP + HSY + HBP;
   localparam int VT = VV + VFP + VSY + VBP;
   localparam int HS_B = HV + HFP, HS_E = HV + HFP + HSY - 1;
   localparam int VS_B = VV + VFP, VS_E = VV + VFP + VSY - 1;
   localparam int FBW = 640;

   // clock / reset
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic display = 1'b1;
   logic ram_ff = 1'b0;
   always #5 clk = ~clk;

   logic [18:0] addr1, addr2;
   logic        rd_en1, rd_en2, hs1, hs2, vs1, vs2, fs1, fs2;
   logic [2:0]  red1, red2, grn1, grn2;
   logic [1:0]  blu1, blu2;
   logic [7:0]  rd_data1, rd_data2;
   logic [7:0]  col1, col2;
   assign col1 = {red1, grn1, blu1};
   assign col2 = {red2, grn2, blu2};

   // RAM models: latency 1 reads combinationally from the registered address, latency 2 adds a register.
   assign rd_data1 = ram_ff ? 8'hFF : addr1[7:0];
   always @(posedge clk) rd_data2 <= ram_ff ? 8'hFF : addr2[7:0];

   vga_frame_reader #(
      .RD_LAT (1),
      .H_VIS (HV), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
      .V_VIS (VV), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP)
   ) dut1 (
      .Clk_100M (clk), .reset (reset), .display (display), .rd_data (rd_data1),
      .addr_r (addr1), .rd_en (rd_en1), .Hsync (hs1), .Vsync (vs1),
      .vgaRed (red1), .vgaGreen (grn1), .vgaBlue (blu1), .frame_start (fs1)
   );

   vga_frame_reader #(
      .RD_LAT (2),
      .H_VIS (HV), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
      .V_VIS (VV), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP)
   ) dut2 (
      .Clk_100M (clk), .reset (reset), .display (display), .rd_data (rd_data2),
      .addr_r (addr2), .rd_en (rd_en2), .Hsync (hs2), .Vsync (vs2),
      .vgaRed (red2), .vgaGreen (grn2), .vgaBlue (blu2), .frame_start (fs2)
   );

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // edges since reset release, and inputs as the DUT saw them at the last edge
   int   n = 0;
   logic rst_s, disp_s;
   always @(posedge clk) begin
      n      <= reset ? 0 : n + 1;
      rst_s  <= reset;
      disp_s <= display;
   end

   // scoreboard
   logic [7:0] exp_q[$];
   int   m_addr;
   logic [7:0] m_col;
   logic m_hs, m_vs;
   int   rd_cnt1, rd_cnt2, hs_low, vs_low, fs_cnt, fs_last, fs_period, first_hs_n, first_fs_n;

   always @(negedge clk) begin
      int k, p, q, h, v, hq, vq;
      logic rd_exp, fs_exp;
      logic [7:0] b;
      rd_exp = 1'b0;
      fs_exp = 1'b0;
      if (rst_s === 1'b1) begin
         exp_q.delete();
         m_addr = 0; m_col = 8'h00; m_hs = 1'b1; m_vs = 1'b1;
         rd_cnt1 = 0; rd_cnt2 = 0; hs_low = 0; vs_low = 0; fs_cnt = 0;
         fs_last = -1; fs_period = 0; first_hs_n = -1; first_fs_n = -1;
      end else if (rst_s === 1'b0 && n % 4 == 0) begin
         k = n / 4;
         p = k - 1;
         h = p % HT;
         v = (p / HT) % VT;
         if (h < HV && v < VV) begin
            rd_exp = 1'b1;
            m_addr = v * FBW + h;
            b = m_addr[7:0];
            exp_q.push_back(ram_ff ? 8'hFF : b);
         end
         if (k >= 2) begin
            q  = k - 2;
            hq = q % HT;
            vq = (q / HT) % VT;
            m_col = 8'h00;
            if (hq < HV && vq < VV) begin
               if (exp_q.size() == 0) begin
                  check("exp_q_underflow", 32'(exp_q.size()), 32'd1);
               end else begin
                  b = exp_q.pop_front();
                  if (disp_s) m_col = b;
               end
            end
            m_hs   = !(hq >= HS_B && hq <= HS_E);
            m_vs   = !(vq >= VS_B && vq <= VS_E);
            fs_exp = (hq == 0) && (vq == 0);
         end
      end
      if (rst_s === 1'b1 || rst_s === 1'b0) begin
         check("d1_rd_en", rd_en1, rd_exp);
         check("d2_rd_en", rd_en2, rd_exp);
         check("d1_addr", addr1, m_addr);
         check("d2_addr", addr2, m_addr);
         check("d1_colour", col1, m_col);
         check("d2_colour", col2, m_col);
         check("d1_hsync", hs1, m_hs);
         check("d2_hsync", hs2, m_hs);
         check("d1_vsync", vs1, m_vs);
         check("d2_vsync", vs2, m_vs);
         check("d1_frame_start", fs1, fs_exp);
         check("d2_frame_start", fs2, fs_exp);
      end
      if (rst_s === 1'b0) begin
         rd_cnt1 += int'(rd_en1);
         rd_cnt2 += int'(rd_en2);
         hs_low  += int'(!hs1);
         vs_low  += int'(!vs1);
         if (!hs1 && first_hs_n < 0) first_hs_n = n;
         if (fs1) begin
            fs_cnt++;
            if (first_fs_n < 0) first_fs_n = n;
            if (fs_last >= 0) fs_period = n - fs_last;
            fs_last = n;
         end
      end
   end

   // driver: wait until the given edge has been seen and the scoreboard has processed it
   task automatic wait_n(input int target);
      int guard;
      guard = 0;
      do begin
         @(posedge clk);
         #1;
         guard++;
      end while (n < target && guard < 20000);
      check("wait_edge", n, target);
      #5;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_hsync", hs1, 1'b1);
      check("rst_vsync", vs2, 1'b1);
      check("rst_colour", col1, 8'h00);
      check("rst_rd_en", rd_en2, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b0;

      wait_n(3);
      check("pre_first_rd_en", rd_en1, 1'b0);
      wait_n(4);
      check("first_rd_en", rd_en1, 1'b1);
      check("first_addr", addr1, 19'd0);

      wait_n(984);
      check("r3c5_addr_lat1", addr1, 19'd1925);
      check("r3c5_addr_lat2", addr2, 19'd1925);
      wait_n(988);
      check("r3c5_colour_lat1", col1, 8'h85);
      check("r3c5_colour_lat2", col2, 8'h85);

      wait_n(8640);
      check("frame_rd_cnt_lat1", rd_cnt1, HV * VV);
      check("frame_rd_cnt_lat2", rd_cnt2, HV * VV);
      check("frame_last_addr", addr1, 19'((VV - 1) * FBW + HV - 1));
      check("frame_vsync_low", vs_low, VSY * HT * 4);
      check("frame_hsync_low", hs_low, VT * HSY * 4);
      check("line_hsync_offset", first_hs_n - first_fs_n, (HV + HFP) * 4);
      check("frame_start_cnt1", fs_cnt, 1);
      wait_n(8648);
      check("frame_start_cnt2", fs_cnt, 2);
      check("frame_period", fs_period, HT * VT * 4);

      reset   = 1'b1;
      ram_ff  = 1'b1;
      display = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      wait_n(100);
      check("blank_colour_lat1", col1, 8'h00);
      check("blank_colour_lat2", col2, 8'h00);
      wait_n(320);
      check("blank_line_rd_cnt", rd_cnt1, HV);
      wait_n(360);
      check("blank_before_on", col1, 8'h00);
      display = 1'b1;
      wait_n(364);
      check("display_on_lat1", col1, 8'hFF);
      check("display_on_lat2", col2, 8'hFF);

      wait_n(3324);
      check("mid_addr", addr1, 19'd6430);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_addr", addr1, 19'd0);
      check("mid_rst_rd_en", rd_en1, 1'b0);
      check("mid_rst_hsync", hs2, 1'b1);
      check("mid_rst_vsync", vs1, 1'b1);
      check("mid_rst_colour", col2, 8'h00);
      reset = 1'b0;
      wait_n(4);
      check("restart_rd_en", rd_en2, 1'b1);
      check("restart_addr", addr2, 19'd0);
      wait_n(8);
      check("restart_colour", col1, 8'hFF);
      check("restart_frame_start", fs2, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
